// File: rtl/imm_pkg.sv
// Shared types and limits for the immediate encoder.
// Latency: none (declarations only).
// Backpressure: not applicable.
package imm_pkg;

  typedef enum logic [2:0] {
    I_T = 3'd0,
    S_T = 3'd1,
    B_T = 3'd2,
    U_T = 3'd3,
    J_T = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    OK    = 2'd0,
    RANGE = 2'd1,
    ALIGN = 2'd2,
    SEL   = 2'd3
  } imm_err_e;

  // Representable immediate ranges per format (B/J maxima are even because bit 0 is implicit)
  localparam int IS_MIN = -2048;
  localparam int IS_MAX = 2047;
  localparam int B_MIN  = -4096;
  localparam int B_MAX  = 4094;
  localparam int J_MIN  = -1048576;
  localparam int J_MAX  = 1048574;

  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Scatters an immediate into the RV32I field layout chosen by sel and grades it.
// Latency: purely combinational.
// Backpressure: none; the enclosing pipeline decides when the result is captured.
module imm_field_pack
  import imm_pkg::*;
(
  input  logic [31:0] tmpl,
  input  logic [31:0] imm,
  input  logic [2:0]  sel,
  output logic [31:0] inst,
  output logic [1:0]  err
);

  // Field insertion and error grading; alignment is tested before range so it wins
  always_comb begin
    inst = tmpl;
    err  = OK;
    case (sel)
      I_T: begin
        inst[31:20] = imm[11:0];
        if (!in_range(imm, IS_MIN, IS_MAX)) err = RANGE;
      end
      S_T: begin
        inst[31:25] = imm[11:5];
        inst[11:7]  = imm[4:0];
        if (!in_range(imm, IS_MIN, IS_MAX)) err = RANGE;
      end
      B_T: begin
        inst[31]    = imm[12];
        inst[30:25] = imm[10:5];
        inst[11:8]  = imm[4:1];
        inst[7]     = imm[11];
        if (imm[0])                           err = ALIGN;
        else if (!in_range(imm, B_MIN, B_MAX)) err = RANGE;
      end
      U_T: begin
        inst[31:12] = imm[31:12];
        if (imm[11:0] != 12'd0) err = RANGE;
      end
      J_T: begin
        inst[31]    = imm[20];
        inst[30:21] = imm[10:1];
        inst[20]    = imm[11];
        inst[19:12] = imm[19:12];
        if (imm[0])                           err = ALIGN;
        else if (!in_range(imm, J_MIN, J_MAX)) err = RANGE;
      end
      default: begin
        // Unknown format: template passes through untouched
        inst = tmpl;
        err  = SEL;
      end
    endcase
  end

endmodule

// File: rtl/imm_enc.sv
// Immediate encoder: two-stage valid/ready pipeline around imm_field_pack, with ok/error statistics.
// Latency: beat accepted at edge N is presented (out_valid=1) after edge N+1; 1 beat/cycle sustained.
// Backpressure: in_ready is combinational from out_ready; S2 holds its word while out_ready is low.
module imm_enc
  import imm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [31:0]      in_imm,
  input  logic [2:0]       in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [1:0]       out_err,
  output logic [CNT_W-1:0] cnt_ok,
  output logic [CNT_W-1:0] cnt_err
);

  logic        s1_valid;
  logic [31:0] s1_inst;
  logic [31:0] s1_imm;
  logic [2:0]  s1_sel;
  logic        s2_valid;
  logic        s1_adv;
  logic        s2_adv;
  logic [31:0] pk_inst;
  logic [1:0]  pk_err;

  assign s2_adv    = !s2_valid | out_ready;
  assign s1_adv    = !s1_valid | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  imm_field_pack u_pack (
    .tmpl (s1_inst),
    .imm  (s1_imm),
    .sel  (s1_sel),
    .inst (pk_inst),
    .err  (pk_err)
  );

  // Stage 1: capture the raw template/immediate/select whenever the stage may move
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_inst <= in_inst;
        s1_imm  <= in_imm;
        s1_sel  <= in_sel;
      end
    end
  end

  // Stage 2: register the packed word and error code; frozen while downstream stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      out_inst <= 32'd0;
      out_err  <= 2'd0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_inst <= pk_inst;
        out_err  <= pk_err;
      end
    end
  end

  // Saturating delivery statistics, bumped on the output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_ok  <= '0;
      cnt_err <= '0;
    end else if (s2_valid && out_ready) begin
      if (out_err == OK) begin
        if (cnt_ok != '1) cnt_ok <= cnt_ok + CNT_W'(1);
      end else begin
        if (cnt_err != '1) cnt_err <= cnt_err + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_enc.sv
// Self-checking bench for imm_enc: directed beats plus randomized traffic against a reference model.
// Latency: checks out_valid timing on isolated beats and ordering under random backpressure.
// Backpressure: out_ready is held low or randomized to exercise stalls and counter saturation.
module tb_imm_enc;

  localparam int TW = 5;
  localparam int SAT = (1 << TW) - 1;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_inst;
  logic [31:0]   in_imm;
  logic [2:0]    in_sel;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [1:0]    out_err;
  logic [TW-1:0] cnt_ok;
  logic [TW-1:0] cnt_err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [33:0] q[$];
  int          e_ok  = 0;
  int          e_err = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_i = 32'd0;
  logic        rnd_bp = 1'b0;

  imm_enc #(.CNT_W(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_imm    (in_imm),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .cnt_ok    (cnt_ok),
    .cnt_err   (cnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic fits(input int v, input int n);
    return (v >= -(1 <<< (n - 1))) && (v < (1 <<< (n - 1)));
  endfunction

  // Reference: {err, word} from the field table and representability rules
  function automatic logic [33:0] model(input logic [31:0] t, input logic [31:0] m, input logic [2:0] s);
    int          v;
    logic [31:0] w;
    logic [1:0]  e;
    v = $signed(m);
    case (s)
      3'd0: begin
        w = (t & 32'h000FFFFF) | ((m & 32'hFFF) << 20);
        e = fits(v, 12) ? 2'd0 : 2'd1;
      end
      3'd1: begin
        w = (t & 32'h01FFF07F) | (((m >> 5) & 32'h7F) << 25) | ((m & 32'h1F) << 7);
        e = fits(v, 12) ? 2'd0 : 2'd1;
      end
      3'd2: begin
        w = (t & 32'h01FFF07F) | (((m >> 12) & 32'h1) << 31) | (((m >> 5) & 32'h3F) << 25)
          | (((m >> 1) & 32'hF) << 8) | (((m >> 11) & 32'h1) << 7);
        e = (m % 2 != 0) ? 2'd2 : (fits(v, 13) ? 2'd0 : 2'd1);
      end
      3'd3: begin
        w = (t & 32'h00000FFF) | (m & 32'hFFFFF000);
        e = (m % 4096 == 0) ? 2'd0 : 2'd1;
      end
      3'd4: begin
        w = (t & 32'h00000FFF) | (((m >> 20) & 32'h1) << 31) | (((m >> 1) & 32'h3FF) << 21)
          | (((m >> 11) & 32'h1) << 20) | (m & 32'h000FF000);
        e = (m % 2 != 0) ? 2'd2 : (fits(v, 21) ? 2'd0 : 2'd1);
      end
      default: begin
        w = t;
        e = 2'd3;
      end
    endcase
    return {e, w};
  endfunction

  // Scoreboard and counter model, sampled mid-cycle
  always @(negedge clk) begin
    logic [33:0] exp;
    if (rst) begin
      q.delete();
      e_ok   = 0;
      e_err  = 0;
      hold_v = 1'b0;
    end else begin
      chk("cnt_ok", 32'(cnt_ok), 32'(e_ok));
      chk("cnt_err", 32'(cnt_err), 32'(e_err));
      if (hold_v && out_valid) chk("hold_inst", out_inst, hold_i);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 32'(q.size()), 32'd1);
        end else begin
          exp = q.pop_front();
          chk("sb_inst", out_inst, exp[31:0]);
          chk("sb_err", 32'(out_err), 32'(exp[33:32]));
          if (exp[33:32] == 2'd0) begin
            if (e_ok < SAT) e_ok++;
          end else begin
            if (e_err < SAT) e_err++;
          end
        end
      end
      hold_v = out_valid && !out_ready;
      hold_i = out_inst;
      if (in_valid && in_ready) q.push_back(model(in_inst, in_imm, in_sel));
    end
  end

  // Random downstream stalls during the random phase
  always @(posedge clk) begin
    #1;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+2; returns at posedge+2 just after the accepting edge
  task automatic send(input logic [31:0] t, input logic [31:0] m, input logic [2:0] s);
    logic rdy;
    int   n;
    in_inst  = t;
    in_imm   = m;
    in_sel   = s;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #2;
      n++;
    end while (!rdy && n < 200);
    chk("accept", 32'(rdy), 32'd1);
  endtask

  // Isolated beat with latency and literal expectation checks
  task automatic one_beat(input string tag, input logic [31:0] t, input logic [31:0] m,
                          input logic [2:0] s, input logic [31:0] xi, input logic [1:0] xe);
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    send(t, m, s);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat_early"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_lat_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_inst"}, out_inst, xi);
    chk({tag, "_err"}, 32'(out_err), 32'(xe));
  endtask

  initial begin
    logic [31:0] t;
    logic [31:0] m;
    logic [2:0]  s;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_inst   = 32'd0;
    in_imm    = 32'd0;
    in_sel    = 3'd0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_cnt_ok", 32'(cnt_ok), 32'd0);
    chk("rst_cnt_err", 32'(cnt_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    one_beat("i_neg1",  32'h00000013, 32'hFFFFFFFF, 3'd0, 32'hFFF00013, 2'd0);
    one_beat("b_neg4",  32'h00000063, 32'hFFFFFFFC, 3'd2, 32'hFE000EE3, 2'd0);
    one_beat("b_odd",   32'h00000063, 32'd4095,     3'd2, 32'h7E000FE3, 2'd2);
    one_beat("j_800",   32'h0000006F, 32'h00000800, 3'd4, 32'h0010006F, 2'd0);
    one_beat("j_range", 32'h0000006F, 32'h00100000, 3'd4, 32'h8000006F, 2'd1);
    one_beat("u_ok",    32'h00000037, 32'h12345000, 3'd3, 32'h12345037, 2'd0);
    one_beat("sel6",    32'h00000037, 32'h00000123, 3'd6, 32'h00000037, 2'd3);
    @(negedge clk);
    chk("dir_cnt_err", 32'(cnt_err), 32'd3);
    chk("dir_cnt_ok", 32'(cnt_ok), 32'd4);

    // Backpressure: two accepts fill the pipe, then in_ready must stay low
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    send(32'h00000013, 32'd1, 3'd0);
    send(32'h00000013, 32'd2, 3'd0);
    in_inst = 32'h00000013;
    in_imm  = 32'd3;
    in_sel  = 3'd0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_inst", out_inst, 32'h00100013);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    send(32'h00000013, 32'd3, 3'd0);
    send(32'h00000013, 32'd4, 3'd0);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("bp_cnt_ok", 32'(cnt_ok), 32'd8);

    // Reset with two beats in flight
    @(posedge clk);
    #2;
    out_ready = 1'b0;
    send(32'h00000013, 32'd5, 3'd0);
    send(32'h00000013, 32'd6, 3'd0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_cnt_ok", 32'(cnt_ok), 32'd0);
    chk("mid_rst_cnt_err", 32'(cnt_err), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);

    // Randomized traffic with random stalls; long enough to saturate the counters
    @(posedge clk);
    #2;
    rnd_bp = 1'b1;
    for (int k = 0; k < 300; k++) begin
      t = $urandom;
      s = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: m = $urandom;
        1: m = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: m = (32'($urandom_range(0, 8191)) - 32'd4096) & 32'hFFFFFFFE;
        3: m = (32'($urandom_range(0, 4194303)) - 32'h00200000) & ((k % 2 == 0) ? 32'hFFFFFFFE : 32'hFFFFFFFF);
        default: m = $urandom & 32'hFFFFF000;
      endcase
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #2;
      end
      send(t, m, s);
    end
    in_valid = 1'b0;
    rnd_bp   = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 50 && q.size() != 0; n++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
